product_accumulator: RTL and testbench

- Downstream consumer of seq_multiplier.
- Sums a block of `len` consecutive signed products (one per multiplier `ready` pulse) into a widened accumulator.
- Presents the block sum on a valid/ready output handshake.
- Forms the accumulate half of a sequential MAC / dot-product path.

---
 rtl/product_acc_pkg.sv | 28 ++
 rtl/product_accumulator_acc_sat_add.sv | 29 ++
 rtl/product_accumulator.sv | 115 +++++++++++
 tb/tb_product_accumulator.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and constant helpers for the product accumulator.
package product_acc_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;

    localparam int SAT_W = 128;

    function automatic int calc_aw(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    function automatic int calc_lw(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_max(input int aw);
        logic signed [SAT_W-1:0] one;
        one = 1;
        return (one << (aw - 1)) - one;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_min(input int aw);
        logic signed [SAT_W-1:0] one;
        one = 1;
        return -(one << (aw - 1));
    endfunction

endpackage

// File: rtl/product_accumulator_acc_sat_add.sv
// AW-bit signed adder with overflow detect; clamps to the signed range
// when PRODUCT_ACC_SATURATE_EN is defined, otherwise wraps.
module acc_sat_add
    import product_acc_pkg::*;
#(
    parameter int AW = 40
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] b,
    output logic signed [AW-1:0] sum,
    output logic                 ovf
);

    logic signed [AW:0] wide;

    // One extra bit holds the true sum; disagreement of the top two bits is overflow.
    assign wide = {a[AW-1], a} + {b[AW-1], b};
    assign ovf  = wide[AW] ^ wide[AW-1];

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam logic signed [AW-1:0] SMAX = AW'(sat_max(AW));
    localparam logic signed [AW-1:0] SMIN = AW'(sat_min(AW));

    assign sum = ovf ? (wide[AW] ? SMIN : SMAX) : wide[AW-1:0];
`else
    assign sum = wide[AW-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of len signed products into a widened accumulator with a
// valid/ready result port. Optional clamping: PRODUCT_ACC_SATURATE_EN.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int GUARD   = 8,
    parameter  int MAX_LEN = 256,
    localparam int AW      = calc_aw(WIDTH, GUARD),
    localparam int LW      = calc_lw(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [LW-1:0]          len,
    input  logic                   prod_valid,
    input  logic signed [2*WIDTH-1:0] product,
    output logic signed [AW-1:0]   acc_out,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic                   busy,
    output logic                   overflow,
    output logic                   dropped
);

    acc_state_t            state;
    logic [LW-1:0]         count;
    logic [LW-1:0]         count_nxt;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         len_eff;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  sum_w;
    logic                  ovf_w;

    assign prod_ext  = {{GUARD{product[2*WIDTH-1]}}, product};
    assign count_nxt = count + LW'(1);

    always_comb begin
        len_eff = len;
        if (len == '0)
            len_eff = LW'(1);
        else if (len > LW'(MAX_LEN))
            len_eff = LW'(MAX_LEN);
    end

    acc_sat_add #(.AW(AW)) u_add (
        .a   (acc_out),
        .b   (prod_ext),
        .sum (sum_w),
        .ovf (ovf_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_out   <= '0;
            count     <= '0;
            len_q     <= '0;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc_out   <= '0;
            count     <= '0;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (prod_valid) begin
                        acc_out   <= prod_ext;
                        count     <= LW'(1);
                        len_q     <= len_eff;
                        busy      <= 1'b1;
                        acc_valid <= (len_eff == LW'(1));
                        state     <= (len_eff == LW'(1)) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_out  <= sum_w;
                        count    <= count_nxt;
                        overflow <= overflow | ovf_w;
                        if (count_nxt == len_q) begin
                            acc_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready && prod_valid) begin
                        // Result taken and next block opened in the same cycle.
                        acc_out   <= prod_ext;
                        count     <= LW'(1);
                        len_q     <= len_eff;
                        acc_valid <= (len_eff == LW'(1));
                        state     <= (len_eff == LW'(1)) ? HOLD : ACCUM;
                    end else if (acc_ready) begin
                        acc_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (prod_valid) begin
                        dropped <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed self-checking bench for product_accumulator.
module tb_product_accumulator;

    localparam int AW  = 40;
    localparam int AW1 = 33;
    localparam int LW  = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  clear;
    logic [LW-1:0]         len;
    logic                  prod_valid;
    logic signed [31:0]    product;
    logic signed [AW-1:0]  acc_out;
    logic                  acc_valid;
    logic                  acc_ready;
    logic                  busy;
    logic                  overflow;
    logic                  dropped;

    logic                  g_clear;
    logic [LW-1:0]         g_len;
    logic                  g_prod_valid;
    logic signed [31:0]    g_product;
    logic signed [AW1-1:0] g_acc_out;
    logic                  g_acc_valid;
    logic                  g_acc_ready;
    logic                  g_busy;
    logic                  g_overflow;
    logic                  g_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    product_accumulator #(.WIDTH(16), .GUARD(8), .MAX_LEN(256)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .len(len),
        .prod_valid(prod_valid), .product(product),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .busy(busy), .overflow(overflow), .dropped(dropped)
    );

    product_accumulator #(.WIDTH(16), .GUARD(1), .MAX_LEN(256)) dut_g1 (
        .clk(clk), .rst_n(rst_n), .clear(g_clear), .len(g_len),
        .prod_valid(g_prod_valid), .product(g_product),
        .acc_out(g_acc_out), .acc_valid(g_acc_valid), .acc_ready(g_acc_ready),
        .busy(g_busy), .overflow(g_overflow), .dropped(g_dropped)
    );

    // Reference add: exact sum, then clamp or wrap into aw signed bits.
    function automatic longint model_add(input longint a, input longint b,
                                         input int aw, output bit ovf);
        longint s, hi, lo, m;
        m  = longint'(1) <<< aw;
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -(longint'(1) <<< (aw - 1));
        s  = a + b;
        ovf = (s > hi) || (s < lo);
`ifdef PRODUCT_ACC_SATURATE_EN
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
`else
        if (s > hi) s = s - m;
        else if (s < lo) s = s + m;
`endif
        return s;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic signed [31:0] p);
        prod_valid = 1'b1;
        product    = p;
        cycle();
        prod_valid = 1'b0;
    endtask

    task automatic g_pulse(input logic signed [31:0] p);
        g_prod_valid = 1'b1;
        g_product    = p;
        cycle();
        g_prod_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic accept();
        acc_ready = 1'b1;
        cycle();
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; len = '0; prod_valid = 1'b0; product = '0;
        acc_ready = 1'b0;
        g_clear = 1'b0; g_len = '0; g_prod_valid = 1'b0; g_product = '0;
        g_acc_ready = 1'b0;
        #1;
        n_checks++;
        if (acc_out !== '0) begin n_fail++; $display("FAIL reset_acc_out got %0d want 0", acc_out); end
        n_checks++;
        if ({acc_valid, busy, overflow, dropped} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {acc_valid, busy, overflow, dropped});
        end
        n_checks++;
        if ({g_acc_valid, g_busy, g_overflow, g_dropped, |g_acc_out} !== 5'b0) begin
            n_fail++; $display("FAIL reset_g1 got %b want 00000", {g_acc_valid, g_busy, g_overflow, g_dropped, |g_acc_out});
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        len = 9'd3;
        pulse(32'sd6);
        repeat (2) cycle();
        pulse(-32'sd10);
        cycle();
        n_checks++;
        if ({acc_valid, busy} !== 2'b01) begin
            n_fail++; $display("FAIL basic_midblock valid/busy got %b want 01", {acc_valid, busy});
        end
        pulse(32'sd100);
        n_checks++;
        if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency acc_valid got %b want 1", acc_valid); end
        n_checks++;
        if (acc_out !== 40'sd96) begin n_fail++; $display("FAIL basic_sum got %0d want 96", acc_out); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (acc_out !== 40'sd96 || acc_valid !== 1'b1) begin
                n_fail++; $display("FAIL basic_hold cycle %0d got %0d/%b want 96/1", i, acc_out, acc_valid);
            end
        end
        accept();
        n_checks++;
        if ({acc_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL basic_release valid/busy got %b want 00", {acc_valid, busy});
        end
    endtask

    task automatic test_len_zero();
        len = '0;
        pulse(-32'sd1);
        n_checks++;
        if (acc_out !== 40'hFF_FFFF_FFFF || acc_valid !== 1'b1) begin
            n_fail++; $display("FAIL len_zero got %h/%b want ffffffffff/1", acc_out, acc_valid);
        end
        accept();
    endtask

    task automatic test_overflow();
        g_len = 9'd4;
        repeat (4) g_pulse(32'sh4000_0000);
        n_checks++;
`ifdef PRODUCT_ACC_SATURATE_EN
        if (g_acc_out !== 33'h0_FFFF_FFFF) begin
            n_fail++; $display("FAIL overflow_sum got %h want 0ffffffff", g_acc_out);
        end
`else
        if (g_acc_out !== 33'h1_0000_0000) begin
            n_fail++; $display("FAIL overflow_sum got %h want 100000000", g_acc_out);
        end
`endif
        n_checks++;
        if ({g_overflow, g_acc_valid} !== 2'b11) begin
            n_fail++; $display("FAIL overflow_flag ovf/valid got %b want 11", {g_overflow, g_acc_valid});
        end
        g_clear = 1'b1;
        cycle();
        g_clear = 1'b0;
        n_checks++;
        if ({g_overflow, g_acc_valid, g_busy, |g_acc_out} !== 4'b0000) begin
            n_fail++; $display("FAIL overflow_clear got %b want 0000", {g_overflow, g_acc_valid, g_busy, |g_acc_out});
        end
    endtask

    task automatic test_back_to_back();
        len = 9'd2;
        pulse(32'sd5);
        pulse(32'sd7);
        n_checks++;
        if (acc_out !== 40'sd12 || acc_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first got %0d/%b want 12/1", acc_out, acc_valid);
        end
        acc_ready = 1'b1;
        pulse(32'sd3);
        acc_ready = 1'b0;
        n_checks++;
        if (acc_out !== 40'sd3 || {acc_valid, busy} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_restart got %0d/%b want 3/01", acc_out, {acc_valid, busy});
        end
        pulse(32'sd4);
        n_checks++;
        if (acc_out !== 40'sd7 || acc_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second got %0d/%b want 7/1", acc_out, acc_valid);
        end
        accept();
    endtask

    task automatic test_stall_drop();
        do_clear();
        len = 9'd2;
        pulse(32'sd5);
        pulse(32'sd7);
        n_checks++;
        if (dropped !== 1'b0) begin n_fail++; $display("FAIL drop_before got %b want 0", dropped); end
        pulse(32'sd99);
        n_checks++;
        if (dropped !== 1'b1 || acc_out !== 40'sd12 || acc_valid !== 1'b1) begin
            n_fail++; $display("FAIL drop_stall got drop=%b sum=%0d valid=%b want 1/12/1", dropped, acc_out, acc_valid);
        end
        accept();
        n_checks++;
        if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL drop_accept valid got %b want 0", acc_valid); end
        pulse(32'sd1);
        pulse(32'sd2);
        n_checks++;
        if (acc_out !== 40'sd3 || acc_valid !== 1'b1 || dropped !== 1'b1) begin
            n_fail++; $display("FAIL drop_next got %0d/%b/%b want 3/1/1", acc_out, acc_valid, dropped);
        end
        accept();
    endtask

    task automatic test_abort();
        len = 9'd4;
        pulse(32'sd50);
        pulse(32'sd50);
        n_checks++;
        if (acc_out !== 40'sd100 || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_partial got %0d/%b want 100/1", acc_out, busy);
        end
        do_clear();
        n_checks++;
        if (acc_out !== '0 || {busy, overflow, acc_valid, dropped} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_clear got %0d/%b want 0/0000", acc_out, {busy, overflow, acc_valid, dropped});
        end
        pulse(32'sd50);
        pulse(32'sd50);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (acc_out !== '0 || {busy, acc_valid, overflow, dropped} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_async got %0d/%b want 0/0000", acc_out, {busy, acc_valid, overflow, dropped});
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        longint             sum;
        logic signed [AW-1:0] exp_v;
        logic signed [31:0] p;
        bit                 ov, o;
        int                 l, lenf;
        do_clear();
        ov = 1'b0;
        for (int b = 0; b < 20; b++) begin
            l    = $urandom_range(0, 6);
            lenf = (l == 0) ? 1 : l;
            len  = LW'(l);
            sum  = 0;
            for (int i = 0; i < lenf; i++) begin
                p = $urandom;
                if (i == 0) sum = p;
                else begin sum = model_add(sum, p, AW, o); ov |= o; end
                pulse(p);
                if (i == 0) len = LW'($urandom_range(0, 511));
                if (i < lenf - 1) begin
                    n_checks++;
                    if ({acc_valid, busy} !== 2'b01) begin
                        n_fail++; $display("FAIL rand_mid blk %0d got %b want 01", b, {acc_valid, busy});
                    end
                    repeat ($urandom_range(0, 2)) cycle();
                end
            end
            exp_v = sum[AW-1:0];
            n_checks++;
            if (acc_out !== exp_v || acc_valid !== 1'b1 || overflow !== ov) begin
                n_fail++; $display("FAIL rand_sum blk %0d got %0d/%b/%b want %0d/1/%b", b, acc_out, acc_valid, overflow, exp_v, ov);
            end
            repeat ($urandom_range(0, 3)) begin
                cycle();
                n_checks++;
                if (acc_out !== exp_v || acc_valid !== 1'b1) begin
                    n_fail++; $display("FAIL rand_hold blk %0d got %0d want %0d", b, acc_out, exp_v);
                end
            end
            accept();
            n_checks++;
            if ({acc_valid, busy} !== 2'b00) begin
                n_fail++; $display("FAIL rand_release blk %0d got %b want 00", b, {acc_valid, busy});
            end
        end
    endtask

    task automatic test_len_clamp();
        longint             sum;
        logic signed [AW-1:0] exp_v;
        logic signed [31:0] p;
        bit                 o;
        do_clear();
        len = 9'd300;
        sum = 0;
        for (int i = 0; i < 256; i++) begin
            p = $urandom;
            sum = (i == 0) ? longint'(p) : model_add(sum, p, AW, o);
            pulse(p);
            if (i == 254) begin
                n_checks++;
                if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_early valid got %b want 0", acc_valid); end
            end
        end
        exp_v = sum[AW-1:0];
        n_checks++;
        if (acc_valid !== 1'b1 || acc_out !== exp_v) begin
            n_fail++; $display("FAIL clamp_done got %0d/%b want %0d/1", acc_out, acc_valid, exp_v);
        end
        accept();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_overflow();
        test_back_to_back();
        test_stall_drop();
        test_abort();
        test_random();
        test_len_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
